multi_clock_gen: RTL and testbench

MULTI_CLOCK_GEN -- requirements
Module: multi_clock_gen

---
 rtl/multi_clock_gen_pkg.sv | 17 +
 rtl/multi_clock_gen_ch.sv | 162 ++++++++++++++++
 rtl/multi_clock_gen.sv | 79 +++++++
 tb/tb_multi_clock_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_clock_gen_pkg.sv
// multi_clock_gen_pkg: shared channel FSM state type and reset-default
// channel configuration for the multi-channel clock generator.
package multi_clock_gen_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_DELAY = 2'd1,
    CH_RUN   = 2'd2,
    CH_DRAIN = 2'd3
  } ch_state_e;

  // Per-channel configuration restored by reset
  localparam int DEF_PERIOD_INIT = 4;
  localparam int DEF_HIGH_INIT   = 2;
  localparam int DEF_PHASE_INIT  = 0;

endpackage

// File: rtl/multi_clock_gen_ch.sv
// clk_gen_ch: one generated-clock channel. Holds a shadow and an active
// configuration, a start-delay counter and a period counter. The output is
// registered and derived from the period counter, so it lags the FSM by one
// cycle. Optional macro MULTI_CLOCK_GEN_ALIGN_EN adds the 'align' input.
module clk_gen_ch
  import multi_clock_gen_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = DEF_PERIOD_INIT,
  parameter int DEF_HIGH   = DEF_HIGH_INIT,
  parameter int DEF_PHASE  = DEF_PHASE_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
`ifdef MULTI_CLOCK_GEN_ALIGN_EN
  input  logic             align,
`endif
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             clk_out,
  output logic             busy
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] per_q, hi_q, ph_q;
  logic [CNT_W-1:0] shd_per_q, shd_hi_q, shd_ph_q;
  logic [CNT_W-1:0] shd_per_d, shd_hi_d, shd_ph_d;
  logic             load_act;
  logic             clk_q, clk_d;
  logic             wrap;

  assign wrap    = (cnt_q == (per_q - CNT_W'(1)));
  assign busy    = (state_q != CH_IDLE);
  assign clk_out = clk_q;

  // Shadow config as it will be after this edge, so loads see a same-cycle write
  always_comb begin
    shd_per_d = shd_per_q;
    shd_hi_d  = shd_hi_q;
    shd_ph_d  = shd_ph_q;
    if (cfg_wr) begin
      shd_per_d = cfg_period;
      shd_hi_d  = cfg_high;
      shd_ph_d  = cfg_phase;
    end
  end

  // Channel FSM next state, counters, active-config load and output level
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    load_act = 1'b0;
    clk_d    = ((state_q == CH_RUN) || (state_q == CH_DRAIN)) && (cnt_q < hi_q);
    case (state_q)
      CH_IDLE: begin
        load_act = 1'b1;
        cnt_d    = '0;
        dly_d    = '0;
        if (enable) begin
          if (shd_ph_d == '0) begin
            state_d = CH_RUN;
          end else begin
            state_d = CH_DELAY;
            dly_d   = shd_ph_d;
          end
        end
      end
      CH_DELAY: begin
        if (!enable) begin
          state_d = CH_IDLE;
          dly_d   = '0;
        end else if (dly_q <= CNT_W'(1)) begin
          state_d = CH_RUN;
          cnt_d   = '0;
          dly_d   = '0;
        end else begin
          dly_d = dly_q - CNT_W'(1);
        end
      end
      CH_RUN: begin
        if (wrap) begin
          cnt_d    = '0;
          load_act = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!enable) begin
          state_d = wrap ? CH_IDLE : CH_DRAIN;
        end
      end
      CH_DRAIN: begin
        if (wrap) begin
          cnt_d    = '0;
          load_act = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (enable) begin
          state_d = CH_RUN;
        end else if (wrap) begin
          state_d = CH_IDLE;
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        dly_d   = '0;
      end
    endcase
`ifdef MULTI_CLOCK_GEN_ALIGN_EN
    if (align) begin
      load_act = 1'b1;
      if ((state_q == CH_RUN) || (state_q == CH_DRAIN)) begin
        cnt_d = '0;
        if (shd_ph_d == '0) begin
          state_d = CH_RUN;
          dly_d   = '0;
        end else begin
          state_d = CH_DELAY;
          dly_d   = shd_ph_d;
        end
      end
    end
`endif
  end

  // State, counters, config registers and output flop; reset truncates at once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CH_IDLE;
      cnt_q     <= '0;
      dly_q     <= '0;
      clk_q     <= 1'b0;
      per_q     <= CNT_W'(DEF_PERIOD);
      hi_q      <= CNT_W'(DEF_HIGH);
      ph_q      <= CNT_W'(DEF_PHASE);
      shd_per_q <= CNT_W'(DEF_PERIOD);
      shd_hi_q  <= CNT_W'(DEF_HIGH);
      shd_ph_q  <= CNT_W'(DEF_PHASE);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      clk_q     <= clk_d;
      shd_per_q <= shd_per_d;
      shd_hi_q  <= shd_hi_d;
      shd_ph_q  <= shd_ph_d;
      if (load_act) begin
        per_q <= shd_per_d;
        hi_q  <= shd_hi_d;
        ph_q  <= shd_ph_d;
      end
    end
  end

endmodule

// File: rtl/multi_clock_gen.sv
// multi_clock_gen: NUM_CH independent programmable clock channels sharing
// one config write port. Invalid writes are dropped and flagged on cfg_err.
// Optional macro MULTI_CLOCK_GEN_ALIGN_EN adds the 'align' input, which
// restarts all running channels from their configured phase.
module multi_clock_gen
  import multi_clock_gen_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = DEF_PERIOD_INIT,
  parameter int DEF_HIGH   = DEF_HIGH_INIT,
  parameter int DEF_PHASE  = DEF_PHASE_INIT,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
`ifdef MULTI_CLOCK_GEN_ALIGN_EN
  input  logic              align,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] busy,
  output logic              cfg_err
);

  logic ch_ok;
  logic cfg_ok;
  logic cfg_err_q;

  // A write is legal only for an existing channel and a period of at least 2
  always_comb begin
    ch_ok = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        ch_ok = 1'b1;
      end
    end
    cfg_ok = ch_ok && (cfg_period >= CNT_W'(2));
  end

  // One-cycle error pulse for every rejected write strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    clk_gen_ch #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH),
      .DEF_PHASE  (DEF_PHASE)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable[gi]),
`ifdef MULTI_CLOCK_GEN_ALIGN_EN
      .align      (align),
`endif
      .cfg_wr     (cfg_we && cfg_ok && (cfg_ch == CH_W'(gi))),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_phase  (cfg_phase),
      .clk_out    (clk_out[gi]),
      .busy       (busy[gi])
    );
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// tb_multi_clock_gen: directed vector table plus hand-written multi-cycle
// sequences for multi_clock_gen (NUM_CH=4, CNT_W=16, defaults 4/2/0).
module tb_multi_clock_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  enable = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic [15:0] cfg_phase = '0;
`ifdef MULTI_CLOCK_GEN_ALIGN_EN
  logic        align = 1'b0;
`endif
  logic [3:0]  clk_out;
  logic [3:0]  busy;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic [3:0]  en;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] per;
    logic [15:0] hi;
    logic [15:0] ph;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[27];

  multi_clock_gen #(
    .NUM_CH (4),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
`ifdef MULTI_CLOCK_GEN_ALIGN_EN
    .align      (align),
`endif
    .clk_out    (clk_out),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] en, input logic we,
                              input logic [1:0] ch, input int p, input int h, input int d,
                              input logic [3:0] ec, input logic [3:0] eb, input logic ee);
    vec_t v;
    v.rst_n = r; v.en = en; v.we = we; v.ch = ch;
    v.per = 16'(p); v.hi = 16'(h); v.ph = 16'(d);
    v.exp_clk = ec; v.exp_busy = eb; v.exp_err = ee;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic r, input logic [3:0] en, input logic we,
                               input logic [1:0] ch, input int p, input int h, input int d);
    rst_n = r; enable = en; cfg_we = we; cfg_ch = ch;
    cfg_period = 16'(p); cfg_high = 16'(h); cfg_phase = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] mask,
                             input logic [3:0] exp_clk, input logic [3:0] exp_busy,
                             input logic exp_err);
    checks++;
    if (((clk_out & mask) !== (exp_clk & mask)) || ((busy & mask) !== (exp_busy & mask)) ||
        (cfg_err !== exp_err)) begin
      errors++;
      $display("[TB] FAIL %s: got clk_out=%b busy=%b cfg_err=%b, want clk_out=%b busy=%b cfg_err=%b (mask %b)",
               name, clk_out, busy, cfg_err, exp_clk, exp_busy, exp_err, mask);
    end
  endtask

  initial begin
    int  hi_cnt;
    bit  e;
    logic [3:0] en_v;
    int  bexp_clk[8]  = '{0, 1, 1, 1, 0, 0, 0, 0};
    int  bexp_busy[8] = '{1, 1, 1, 1, 1, 1, 0, 0};

    // Reset, ch0 default 4/2/0 run and drain, rejected writes, ch0+ch2 together
    vecs[0]  = mk(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vecs[1]  = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vecs[2]  = mk(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0);
    vecs[3]  = mk(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 0);
    vecs[4]  = mk(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 0);
    vecs[5]  = mk(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0);
    vecs[6]  = mk(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0);
    vecs[7]  = mk(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 0);
    vecs[8]  = mk(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0001, 4'b0001, 0);
    vecs[9]  = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0);
    vecs[10] = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vecs[11] = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vecs[12] = mk(1, 4'b0000, 1, 1, 1, 1, 0, 4'b0000, 4'b0000, 1);
    vecs[13] = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vecs[14] = mk(1, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 1);
    vecs[15] = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    vecs[16] = mk(1, 4'b0000, 1, 2, 3, 1, 0, 4'b0000, 4'b0000, 0);
    vecs[17] = mk(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0000, 4'b0101, 0);
    vecs[18] = mk(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0101, 4'b0101, 0);
    vecs[19] = mk(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0001, 4'b0101, 0);
    vecs[20] = mk(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0000, 4'b0101, 0);
    vecs[21] = mk(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0100, 4'b0101, 0);
    vecs[22] = mk(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0001, 4'b0101, 0);
    vecs[23] = mk(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0001, 4'b0101, 0);
    vecs[24] = mk(1, 4'b0101, 0, 0, 0, 0, 0, 4'b0100, 4'b0101, 0);
    vecs[25] = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0100, 0);
    vecs[26] = mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].we, vecs[i].ch,
                    int'(vecs[i].per), int'(vecs[i].hi), int'(vecs[i].ph));
      checkOutput($sformatf("vec%0d", i), 4'b1111, vecs[i].exp_clk, vecs[i].exp_busy, vecs[i].exp_err);
    end

    // ch1 P=8 H=3 D=5: first rise 6 cycles after enable, 3/8 duty for 4 periods
    applyStimulus(1, 4'b0000, 1, 1, 8, 3, 5);
    checkOutput("ch1_cfg", 4'b0010, 4'b0000, 4'b0000, 0);
    applyStimulus(1, 4'b0010, 0, 0, 0, 0, 0);
    checkOutput("ch1_start", 4'b0010, 4'b0000, 4'b0010, 0);
    hi_cnt = 0;
    for (int k = 1; k <= 37; k++) begin
      applyStimulus(1, 4'b0010, 0, 0, 0, 0, 0);
      e = (k >= 6) && (((k - 6) % 8) < 3);
      checkOutput($sformatf("ch1_phase_k%0d", k), 4'b0010, e ? 4'b0010 : 4'b0000, 4'b0010, 0);
      if (k >= 6 && clk_out[1]) hi_cnt++;
    end
    checks++;
    if (hi_cnt != 12) begin
      errors++;
      $display("[TB] FAIL ch1_duty: high cycles %0d, want 12", hi_cnt);
    end

    // ch3 P=6 H=3: enable dropped at cnt=1, full period completes, then idle
    applyStimulus(1, 4'b0010, 1, 3, 6, 3, 0);
    for (int k = 0; k < 8; k++) begin
      en_v = (k < 2) ? 4'b1010 : 4'b0010;
      applyStimulus(1, en_v, 0, 0, 0, 0, 0);
      checkOutput($sformatf("ch3_drain_k%0d", k), 4'b1000,
                  (bexp_clk[k] != 0) ? 4'b1000 : 4'b0000,
                  (bexp_busy[k] != 0) ? 4'b1000 : 4'b0000, 0);
    end

    // ch0 defaults: P=10 written mid-period applies next period; P=1 rejected
    for (int k = 0; k <= 30; k++) begin
      if (k == 2)       applyStimulus(1, 4'b0011, 1, 0, 10, 2, 0);
      else if (k == 17) applyStimulus(1, 4'b0011, 1, 0, 1, 2, 0);
      else              applyStimulus(1, 4'b0011, 0, 0, 0, 0, 0);
      if (k == 0)     e = 1'b0;
      else if (k < 5) e = ((k - 1) % 4) < 2;
      else            e = ((k - 5) % 10) < 2;
      checkOutput($sformatf("ch0_reload_k%0d", k), 4'b0001, e ? 4'b0001 : 4'b0000, 4'b0001, k == 17);
    end

    // All channels running, one-cycle reset with a bad write, defaults back
    for (int k = 0; k < 3; k++) applyStimulus(1, 4'b1111, 0, 0, 0, 0, 0);
    applyStimulus(0, 4'b1111, 1, 0, 1, 0, 0);
    checkOutput("reset_all", 4'b1111, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, 4'b1111, 0, 0, 0, 0, 0);
      e = (k >= 1) && (((k - 1) % 4) < 2);
      checkOutput($sformatf("post_reset_k%0d", k), 4'b1111, e ? 4'b1111 : 4'b0000, 4'b1111, 0);
    end

`ifdef MULTI_CLOCK_GEN_ALIGN_EN
    // Align with same-cycle write of ch1 phase 2: ch1 rises 2 cycles after ch0
    begin
      logic [3:0] aexp[5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001};
      align = 1'b1;
      applyStimulus(1, 4'b1111, 1, 1, 4, 2, 2);
      align = 1'b0;
      for (int k = 0; k < 5; k++) begin
        applyStimulus(1, 4'b1111, 0, 0, 0, 0, 0);
        checkOutput($sformatf("align_k%0d", k + 1), 4'b0011, aexp[k], 4'b0011, 0);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
